twiddle_gen: RTL and testbench
==============================

# twiddle_gen

Parametrised, streaming twiddle-factor generator for the radix-2 FFT datapath. A single quarter-wave cosine table in Q1.(DATA_W-1) serves every FFT size up to 2^LOG2_NMAX. On a start command the block emits W_N^k for k = 0..N/2-1 over a valid/ready stream, with forward or inverse (conjugate) mode selectable at run time. It replaces fixed 16-entry twiddle tables and feeds the butterfly stage controller.

## Interface
- DATA_W, 16: width of each real/imag output, two's complement Q1.(DATA_W-1)
- LOG2_NMAX, 6: log2 of the largest supported FFT size; must be >= 2. The table holds NMAX/4+1 entries.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; accepted only when busy=0
- log2_n  in  $clog2(LOG2_NMAX+1)  FFT size for this command; sampled on accept
- inverse  in  1  1 = conjugate twiddles (IFFT); sampled on accept
- busy  out  1  command in progress
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- out_re  out  DATA_W  cos(2πk/N)
- out_im  out  DATA_W  -sin(2πk/N) when forward; +sin(2πk/N) when inverse
- out_idx  out  LOG2_NMAX-1  k of the current word
- out_last  out  1  high with the word k = N/2-1

## Operation
- Table entries: C[i] = round(cos(π·i/(2Q))·(2^(DATA_W-1)-1)) for i = 0..Q, where Q = NMAX/4. The table is constant and built at elaboration. C[0] = 2^(DATA_W-1)-1 and C[Q] = 0. No entry equals -2^(DATA_W-1), so negation never overflows.
- log2_n clamping on accept: values < 2 are treated as 2; values > LOG2_NMAX are treated as LOG2_NMAX. N is 2^(clamped value).
- Table index: m = k << (LOG2_NMAX - log2_n), with m in [0, NMAX/2). Quadrant q = m[LOG2_NMAX-2]. r = m mod Q.
- q=0: cos = C[r], sin = C[Q-r].
- q=1: cos = -C[Q-r], sin = C[r].
- Output: out_re = cos. out_im = inverse ? sin : -sin. Negation is two's complement of a non-negative entry.
- FSM states:
  - IDLE: busy=0. start moves to RUN with k=0 and latches log2_n and inverse.
  - RUN: k increments each time stage 1 advances. After issuing k = N/2-1 the FSM moves to DRAIN.
  - DRAIN: waits for the handshake on the last word, then returns to IDLE.
- start while busy=1 is ignored; it is neither queued nor restarts the command.
- Changes to log2_n or inverse after accept have no effect on the command in progress.

## Timing
- Two-stage pipeline:
  - Stage 1 registers quadrant, r and sign flags.
  - Stage 2 registers the table read and negation into out_*.
- Latency: start accepted at edge 0 gives first out_valid after edge 2.
- Throughput: one word per cycle while out_ready=1. There are no bubbles between words of one command.
- Pipeline enable = !out_valid | out_ready at each stage.
- Backpressure: while out_valid=1 and out_ready=0, out_re, out_im, out_idx and out_last hold stable. No word is dropped or duplicated.
- busy:
  - Rises at the edge that accepts start.
  - Falls at the edge that completes the handshake on the out_last word.
  - A new start is accepted on the following cycle at the earliest.
- Asynchronous reset: all outputs go to 0 (busy, out_valid, out_re, out_im, out_idx, out_last). The FSM goes to IDLE and the pipeline is flushed. Reset mid-command abandons the command with no partial output after reset is released.
- N=4 (minimum size) emits exactly 2 words. N=NMAX emits NMAX/2 words; k wraps only by returning to IDLE.

## Test plan
- DATA_W=16, LOG2_NMAX=6, log2_n=6, forward, ready held high -> 32 consecutive valid cycles starting 2 cycles after accept.
  - idx0 = (0x7fff, 0x0000)
  - idx8 = (0x5a82, 0xa57e)
  - idx16 = (0x0000, 0x8001)
  - idx24 = (0xa57e, 0xa57e)
  - out_last only on idx31, busy low the next cycle
- log2_n=3, inverse=1 -> 4 words:
  - (0x7fff, 0x0000)
  - (0x5a82, 0x5a82)
  - (0x0000, 0x7fff)
  - (0xa57e, 0x5a82)
- N=64 with out_ready low for 5 cycles at idx10 -> idx10 held stable through the stall; stream resumes at idx11. Bench compares all 32 words with a reference model: no skip, no duplicate.
- start pulsed with log2_n=6, then pulsed again while busy with log2_n=2 -> second pulse ignored, 32 words emitted. log2_n=1 -> clamped to N=4, 2 words emitted.
- rst_n asserted at idx5 of an N=64 run -> all outputs 0 immediately. After release, a new N=8 command produces a correct 4-word stream.
- Back-to-back commands (start on the cycle after busy falls) -> second stream starts 2 cycles after its accept with correct idx0.

Source files
------------

// File: rtl/twiddle_gen.sv
// Streaming radix-2 FFT twiddle generator: emits W_N^k, k = 0..N/2-1, from one
// quarter-wave cosine table, through a two-stage valid/ready pipeline.
module twiddle_gen #(
  parameter int DATA_W    = 16,
  parameter int LOG2_NMAX = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(LOG2_NMAX+1)-1:0]       log2_n,
  input  logic                                 inverse,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [DATA_W-1:0]             out_re,
  output logic signed [DATA_W-1:0]             out_im,
  output logic [LOG2_NMAX-2:0]                 out_idx,
  output logic                                 out_last
);

  localparam int LN_W = $clog2(LOG2_NMAX + 1);
  localparam int K_W  = LOG2_NMAX - 1;
  localparam int Q    = 1 << (LOG2_NMAX - 2);
  localparam logic [K_W-1:0] R_MASK = K_W'(Q - 1);
  localparam logic [K_W-1:0] Q_K    = K_W'(Q);

  function automatic logic [(Q+1)*DATA_W-1:0] build_cos_tbl();
    logic [(Q+1)*DATA_W-1:0] t;
    real x, term, sum, scale;
    int  v;
    t     = '0;
    scale = real'((1 << (DATA_W - 1)) - 1);
    for (int i = 0; i <= Q; i++) begin
      x    = 3.14159265358979323846 * real'(i) / (2.0 * real'(Q));
      term = 1.0;
      sum  = 1.0;
      for (int n = 1; n <= 16; n++) begin
        term = -term * x * x / real'((2 * n - 1) * (2 * n));
        sum  = sum + term;
      end
      v = $rtoi(sum * scale + 0.5);
      if (v < 0) v = 0;
      if (i == 0) v = (1 << (DATA_W - 1)) - 1;
      if (i == Q) v = 0;
      t[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
    end
    return t;
  endfunction

  localparam logic [(Q+1)*DATA_W-1:0] COS_TBL = build_cos_tbl();

  function automatic logic signed [DATA_W-1:0] tbl(input logic [K_W-1:0] i);
    return COS_TBL[int'(i)*DATA_W +: DATA_W];
  endfunction

  // Entries are never the most negative code, so this cannot overflow.
  function automatic logic signed [DATA_W-1:0] neg_if(input logic signed [DATA_W-1:0] v,
                                                      input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [LN_W-1:0] clamp_ln(input logic [LN_W-1:0] v);
    if (v < LN_W'(2)) return LN_W'(2);
    if (v > LN_W'(LOG2_NMAX)) return LN_W'(LOG2_NMAX);
    return v;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic [LN_W-1:0] ln_q, ln_d;
  logic            inv_q, inv_d;

  logic            vld_p1_q, quad_p1_q, negim_p1_q, last_p1_q;
  logic [K_W-1:0]  r_p1_q, idx_p1_q;

  logic                     vld_p2_q, last_p2_q;
  logic signed [DATA_W-1:0] re_p2_q, im_p2_q;
  logic [K_W-1:0]           idx_p2_q;

  logic                     en, issue;
  logic [K_W:0]             half_n;
  logic [K_W-1:0]           k_last, m;
  logic [LN_W-1:0]          sh;
  logic signed [DATA_W-1:0] cos_mag, sin_mag;

  assign en     = !vld_p2_q | out_ready;
  assign issue  = (state_q == S_RUN) && en;
  assign half_n = (K_W+1)'(1) << (ln_q - LN_W'(1));
  assign k_last = K_W'(half_n - (K_W+1)'(1));
  assign sh     = LN_W'(LOG2_NMAX) - ln_q;
  assign m      = k_q << sh;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ln_d    = ln_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          ln_d    = clamp_ln(log2_n);
          inv_d   = inverse;
        end
      end
      S_RUN: begin
        if (en) begin
          if (k_q == k_last) state_d = S_DRAIN;
          else               k_d     = k_q + K_W'(1);
        end
      end
      S_DRAIN: begin
        if (vld_p2_q && out_ready && last_p2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ln_q    <= LN_W'(2);
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ln_q    <= ln_d;
      inv_q   <= inv_d;
    end
  end

  // Stage 1: quadrant, offset within quadrant and imaginary sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      quad_p1_q  <= 1'b0;
      negim_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      r_p1_q     <= '0;
      idx_p1_q   <= '0;
    end else if (en) begin
      vld_p1_q   <= issue;
      quad_p1_q  <= m[K_W-1];
      negim_p1_q <= !inv_q;
      last_p1_q  <= (k_q == k_last);
      r_p1_q     <= m & R_MASK;
      idx_p1_q   <= k_q;
    end
  end

  // In the second quadrant cos and sin swap table ends and cos turns negative.
  assign cos_mag = quad_p1_q ? tbl(Q_K - r_p1_q) : tbl(r_p1_q);
  assign sin_mag = quad_p1_q ? tbl(r_p1_q) : tbl(Q_K - r_p1_q);

  // Stage 2: table read and negation into the output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      re_p2_q   <= '0;
      im_p2_q   <= '0;
      idx_p2_q  <= '0;
    end else if (en) begin
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
      re_p2_q   <= neg_if(cos_mag, quad_p1_q);
      im_p2_q   <= neg_if(sin_mag, negim_p1_q);
      idx_p2_q  <= idx_p1_q;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = vld_p2_q;
  assign out_re    = re_p2_q;
  assign out_im    = im_p2_q;
  assign out_idx   = idx_p2_q;
  assign out_last  = last_p2_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (DATA_W=16, LOG2_NMAX=6): hand-computed
// twiddle constants plus a trigonometric reference for whole streams.
module tb_twiddle_gen;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [2:0]         log2_n = 3'd0;
  logic               inverse = 1'b0;
  logic               busy;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic [4:0]         out_idx;
  logic               out_last;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] cap_re [64];
  logic [15:0] cap_im [64];

  twiddle_gen #(.DATA_W(16), .LOG2_NMAX(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .log2_n    (log2_n),
    .inverse   (inverse),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [37:0] model(input int k, input int n, input bit inv);
    real th, c, s;
    int cm, sm;
    logic signed [15:0] re, im;
    th = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    c  = $cos(th);
    s  = $sin(th);
    cm = $rtoi(((c < 0.0) ? -c : c) * 32767.0 + 0.5);
    sm = $rtoi(((s < 0.0) ? -s : s) * 32767.0 + 0.5);
    re = (c < 0.0) ? -16'(cm) : 16'(cm);
    im = inv ? 16'(sm) : -16'(sm);
    return {re, im, 5'(k), (k == n / 2 - 1)};
  endfunction

  function automatic logic [37:0] dut_word();
    return {out_re, out_im, out_idx, out_last};
  endfunction

  task automatic do_start(input int ln, input bit inv);
    log2_n  = 3'(ln);
    inverse = inv;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("busy_rise", 64'(busy), 64'(1));
  endtask

  task automatic latency();
    chk("lat_e0", 64'(out_valid), 64'(0));
    tick();
    chk("lat_e1", 64'(out_valid), 64'(0));
    tick();
    chk("lat_e2", 64'(out_valid), 64'(1));
    chk("lat_idx0", 64'(out_idx), 64'(0));
  endtask

  // Consume a stream; optionally stall the consumer on one word.
  task automatic stream(input int n, input bit inv, input int nwords,
                        input int stall_idx, input int stall_len);
    int e = 0, cyc = 0, held = 0, gap = 0;
    logic [37:0] exp;
    out_ready = 1'b1;
    while (e < nwords && cyc < 300) begin
      if (out_valid) begin
        exp = model(e, n, inv);
        if (e == stall_idx && held < stall_len) begin
          out_ready = 1'b0;
          chk("stall_hold", 64'(dut_word()), 64'(exp));
          held++;
        end else begin
          out_ready = 1'b1;
          chk("word", 64'(dut_word()), 64'(exp));
          cap_re[e] = out_re;
          cap_im[e] = out_im;
          e++;
        end
      end else if (e > 0) begin
        gap++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk("word_count", 64'(e), 64'(nwords));
    chk("no_bubble", 64'(gap), 64'(0));
    chk("busy_fall", 64'(busy), 64'(0));
    chk("valid_end", 64'(out_valid), 64'(0));
  endtask

  initial begin
    int cyc;
    // Reset state
    @(negedge clk);
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'({out_re, out_im, out_idx, out_last}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // N=64 forward
    do_start(6, 1'b0);
    latency();
    stream(64, 1'b0, 32, -1, 0);
    chk("n64_idx0",  64'({cap_re[0],  cap_im[0]}),  64'(32'h7fff_0000));
    chk("n64_idx8",  64'({cap_re[8],  cap_im[8]}),  64'(32'h5a82_a57e));
    chk("n64_idx16", 64'({cap_re[16], cap_im[16]}), 64'(32'h0000_8001));
    chk("n64_idx24", 64'({cap_re[24], cap_im[24]}), 64'(32'ha57e_a57e));

    // N=8 inverse
    tick();
    do_start(3, 1'b1);
    stream(8, 1'b1, 4, -1, 0);
    chk("n8i_w0", 64'({cap_re[0], cap_im[0]}), 64'(32'h7fff_0000));
    chk("n8i_w1", 64'({cap_re[1], cap_im[1]}), 64'(32'h5a82_5a82));
    chk("n8i_w2", 64'({cap_re[2], cap_im[2]}), 64'(32'h0000_7fff));
    chk("n8i_w3", 64'({cap_re[3], cap_im[3]}), 64'(32'ha57e_5a82));

    // Backpressure on idx10
    tick();
    do_start(6, 1'b0);
    stream(64, 1'b0, 32, 10, 5);

    // Second start while busy is ignored; inputs changed after accept
    tick();
    do_start(6, 1'b0);
    log2_n  = 3'd2;
    inverse = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    stream(64, 1'b0, 32, -1, 0);
    tick();
    tick();
    chk("no_restart_valid", 64'(out_valid), 64'(0));
    chk("no_restart_busy",  64'(busy), 64'(0));

    // log2_n=1 clamps to N=4
    do_start(1, 1'b0);
    stream(4, 1'b0, 2, -1, 0);
    chk("n4_w1", 64'({cap_re[1], cap_im[1]}), 64'(32'h0000_8001));

    // Asynchronous reset mid-command
    tick();
    do_start(6, 1'b0);
    cyc = 0;
    while (!(out_valid && out_idx == 5'd5) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reach_idx5", 64'(out_idx), 64'(5));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(busy), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_data",  64'({out_re, out_im, out_idx, out_last}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_busy",  64'(busy), 64'(0));
    do_start(3, 1'b0);
    stream(8, 1'b0, 4, -1, 0);
    chk("n8f_w3", 64'({cap_re[3], cap_im[3]}), 64'(32'ha57e_a57e));

    // Back-to-back: start on the cycle right after busy falls
    do_start(2, 1'b0);
    stream(4, 1'b0, 2, -1, 0);
    do_start(3, 1'b0);
    latency();
    chk("b2b_w0", 64'({out_re, out_im}), 64'(32'h7fff_0000));
    stream(8, 1'b0, 4, -1, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
